avalon_burst_ram_slave: RTL and testbench

//   Avalon-MM burst responder backed by an internal dword RAM. It serves the memory-side
//   end of the bus driven by the CPU memory master: single and 1..4-dword bursts.

---
 rtl/avalon_burst_ram_slave.sv | 207 ++++++++++++++++++++
 tb/tb_avalon_burst_ram_slave.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_burst_ram_slave.sv
// Avalon-MM burst responder backed by an internal dword RAM.
// Serves single and 1..4-dword bursts, one command outstanding at a time,
// with a configurable number of wait states before a command is accepted
// and a configurable read latency.
//
// Handshake: a command or write beat transfers on a rising clock edge where
// (avs_read | avs_write) is high and avs_waitrequest is low; avs_waitrequest
// never depends combinationally on the request inputs. Read beats are pushed
// with avs_readdatavalid, one per cycle, and cannot be back-pressured.
module avalon_burst_ram_slave #(
    parameter int ADDR_WIDTH   = 10,
    parameter int WAIT_STATES  = 0,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] avs_address,
    input  logic [31:0] avs_writedata,
    input  logic [3:0]  avs_byteenable,
    input  logic [2:0]  avs_burstcount,
    input  logic        avs_write,
    input  logic        avs_read,
    output logic        avs_waitrequest,
    output logic        avs_readdatavalid,
    output logic [31:0] avs_readdata,
    output logic        protocol_error,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ_WAIT = 2'd2,
        READ_DATA = 2'd3
    } state_t;

    localparam int                    DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [2:0]            WAIT_MAX = 3'(WAIT_STATES);
    localparam logic [1:0]            LAT_M1   = 2'(READ_LATENCY - 1);
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = 1;

    state_t                  state;
    state_t                  state_next;
    logic [2:0]              wait_cnt;
    logic [ADDR_WIDTH-1:0]   cmd_idx;     // RAM index of the next beat
    logic [1:0]              remaining;   // write: beats still to come; read: beats after the current one
    logic [1:0]              lat_cnt;
    logic [31:0]             ram [DEPTH];

    logic [ADDR_WIDTH-1:0]   req_idx;
    logic [1:0]              req_len_m1;
    logic                    req_len_bad;
    logic                    waits_done;

    logic                    accept_wr;
    logic                    accept_rd;
    logic                    beat_wr;
    logic                    emit_beat;
    logic                    emit_dec;
    logic                    err_set;
    logic                    ram_we;
    logic [ADDR_WIDTH-1:0]   ram_waddr;

    // Byte offset and address bits above the RAM are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{avs_address[31:ADDR_WIDTH+2], avs_address[1:0]};

    assign req_idx    = avs_address[ADDR_WIDTH+1:2];
    assign waits_done = (wait_cnt == WAIT_MAX);
    assign dbg_state  = state;

    // Decode burstcount into length-1; 0 means a single beat, 5..7 clamp to 4 and are illegal.
    always_comb begin
        req_len_m1  = 2'd0;
        req_len_bad = 1'b0;
        case (avs_burstcount)
            3'd0, 3'd1: req_len_m1 = 2'd0;
            3'd2:       req_len_m1 = 2'd1;
            3'd3:       req_len_m1 = 2'd2;
            3'd4:       req_len_m1 = 2'd3;
            default: begin
                req_len_m1  = 2'd3;
                req_len_bad = 1'b1;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state, stall output and datapath strobes.
    always_comb begin
        state_next      = state;
        avs_waitrequest = 1'b1;
        accept_wr       = 1'b0;
        accept_rd       = 1'b0;
        beat_wr         = 1'b0;
        emit_beat       = 1'b0;
        emit_dec        = 1'b0;
        err_set         = 1'b0;
        ram_we          = 1'b0;
        ram_waddr       = req_idx;
        case (state)
            IDLE: begin
                avs_waitrequest = !waits_done;
                if ((avs_read || avs_write) && waits_done) begin
                    if (avs_write) begin
                        // Write wins over a simultaneous read.
                        accept_wr = 1'b1;
                        ram_we    = 1'b1;
                        ram_waddr = req_idx;
                        if (req_len_m1 != 2'd0) state_next = WRITE;
                    end else begin
                        accept_rd  = 1'b1;
                        state_next = READ_WAIT;
                    end
                    if (req_len_bad) err_set = 1'b1;
                end
                if (avs_read && avs_write) err_set = 1'b1;
            end
            WRITE: begin
                avs_waitrequest = 1'b0;
                if (avs_write) begin
                    beat_wr   = 1'b1;
                    ram_we    = 1'b1;
                    ram_waddr = cmd_idx;
                    if (remaining == 2'd1) state_next = IDLE;
                end
                if (avs_read) err_set = 1'b1;
            end
            READ_WAIT: begin
                if (lat_cnt == 2'd0) begin
                    emit_beat  = 1'b1;
                    state_next = READ_DATA;
                end
            end
            READ_DATA: begin
                // The last beat is held on the bus for one cycle before returning to IDLE.
                if (remaining != 2'd0) begin
                    emit_beat = 1'b1;
                    emit_dec  = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Wait-state counter, burst bookkeeping, read beat register and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt          <= 3'd0;
            cmd_idx           <= '0;
            remaining         <= 2'd0;
            lat_cnt           <= 2'd0;
            avs_readdatavalid <= 1'b0;
            avs_readdata      <= 32'd0;
            protocol_error    <= 1'b0;
        end else begin
            avs_readdatavalid <= 1'b0;
            if (err_set) protocol_error <= 1'b1;

            if (accept_wr || accept_rd) begin
                wait_cnt <= 3'd0;
            end else if (state == IDLE && (avs_read || avs_write) && !waits_done) begin
                wait_cnt <= wait_cnt + 3'd1;
            end

            if (accept_wr) begin
                cmd_idx   <= req_idx + IDX_ONE;
                remaining <= req_len_m1;
            end
            if (accept_rd) begin
                cmd_idx   <= req_idx;
                remaining <= req_len_m1;
                lat_cnt   <= LAT_M1;
            end
            if (beat_wr) begin
                cmd_idx   <= cmd_idx + IDX_ONE;
                remaining <= remaining - 2'd1;
            end

            if (state == READ_WAIT && lat_cnt != 2'd0) lat_cnt <= lat_cnt - 2'd1;

            if (emit_beat) begin
                avs_readdatavalid <= 1'b1;
                avs_readdata      <= ram[cmd_idx];
                cmd_idx           <= cmd_idx + IDX_ONE;
            end
            if (emit_dec) remaining <= remaining - 2'd1;
        end
    end

    // RAM write port with byte lanes; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (avs_byteenable[b]) ram[ram_waddr][8*b +: 8] <= avs_writedata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_avalon_burst_ram_slave.sv
// Bench for avalon_burst_ram_slave: directed cases plus randomized bursts,
// checked against a dword-array memory model and an expected-beat queue.
module tb_avalon_burst_ram_slave;

    localparam int AW    = 4;
    localparam int WS    = 3;
    localparam int RL    = 2;
    localparam int DEPTH = 1 << AW;

    // ---------------- clock / reset ----------------
    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] avs_address    = '0;
    logic [31:0] avs_writedata  = '0;
    logic [3:0]  avs_byteenable = '0;
    logic [2:0]  avs_burstcount = '0;
    logic        avs_write      = 1'b0;
    logic        avs_read       = 1'b0;
    logic        avs_waitrequest;
    logic        avs_readdatavalid;
    logic [31:0] avs_readdata;
    logic        protocol_error;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    avalon_burst_ram_slave #(
        .ADDR_WIDTH   (AW),
        .WAIT_STATES  (WS),
        .READ_LATENCY (RL)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .avs_address       (avs_address),
        .avs_writedata     (avs_writedata),
        .avs_byteenable    (avs_byteenable),
        .avs_burstcount    (avs_burstcount),
        .avs_write         (avs_write),
        .avs_read          (avs_read),
        .avs_waitrequest   (avs_waitrequest),
        .avs_readdatavalid (avs_readdatavalid),
        .avs_readdata      (avs_readdata),
        .protocol_error    (protocol_error),
        .dbg_state         (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    int          beats_seen = 0;
    logic [31:0] model_mem [DEPTH];
    bit          exp_err = 1'b0;
    logic [31:0] exp_q [$];
    bit          first_q [$];
    int          acc_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int burst_len(input logic [2:0] bc);
        if (bc == 3'd0) return 1;
        if (bc > 3'd4)  return 4;
        return int'(bc);
    endfunction

    function automatic void model_write(input int idx, input logic [31:0] d, input logic [3:0] be);
        for (int b = 0; b < 4; b++) begin
            if (be[b]) model_mem[idx % DEPTH][8*b +: 8] = d[8*b +: 8];
        end
    endfunction

    // ---------------- monitor ----------------
    logic [31:0] last_beat = '0;
    int          prev_beat_cyc = 0;

    always @(negedge clk) begin
        logic [31:0] e;
        bit          f;
        int          a;
        if (!rst_n) begin
            last_beat = '0;
        end else if (avs_readdatavalid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_readdatavalid: got data %h, expected no beat (t=%0t)", avs_readdata, $time);
            end else begin
                e = exp_q.pop_front();
                f = first_q.pop_front();
                check("readdata", avs_readdata, e);
                if (f) begin
                    a = acc_q.pop_front();
                    check("read_latency", 32'(cyc - a), 32'(RL));
                end else begin
                    check("read_beat_gap", 32'(cyc - prev_beat_cyc), 32'd1);
                end
                prev_beat_cyc = cyc;
                last_beat     = e;
                beats_seen++;
            end
        end else begin
            check("readdata_hold", avs_readdata, last_beat);
        end
    end

    // ---------------- driver tasks ----------------
    // Counts stalled cycles with the request up, then returns at the negedge after the transfer edge.
    task automatic wait_accept(output int waits);
        int guard;
        waits = 0;
        guard = 0;
        #1;
        while (avs_waitrequest && guard < 200) begin
            waits++;
            guard++;
            @(negedge clk);
            #1;
        end
        if (avs_waitrequest) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: waitrequest still 1 after %0d cycles, expected 0", guard);
        end
        @(negedge clk);
    endtask

    // Lets any read in flight drain so the next command starts from IDLE with a cleared counter.
    task automatic wait_idle();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL read_drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
            exp_q.delete();
            first_q.delete();
            acc_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [2:0] bc,
                            input logic [3:0][31:0] d, input logic [3:0][3:0] be,
                            input bit gaps, input bit also_read);
        int len;
        int idx;
        int waits;
        wait_idle();
        len = burst_len(bc);
        idx = int'(addr[AW+1:2]);
        avs_address    = addr;
        avs_burstcount = bc;
        avs_write      = 1'b1;
        avs_read       = also_read;
        avs_writedata  = d[0];
        avs_byteenable = be[0];
        wait_accept(waits);
        avs_read = 1'b0;
        check("write_wait_states", 32'(waits), 32'(WS));
        model_write(idx, d[0], be[0]);
        if (also_read || bc > 3'd4) exp_err = 1'b1;
        for (int i = 1; i < len; i++) begin
            if (gaps) begin
                avs_write = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            avs_write      = 1'b1;
            avs_address    = $urandom();
            avs_writedata  = d[i];
            avs_byteenable = be[i];
            #1;
            check("write_beat_waitrequest", 32'(avs_waitrequest), 32'd0);
            @(negedge clk);
            model_write(idx + i, d[i], be[i]);
        end
        avs_write = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [2:0] bc);
        int len;
        int idx;
        int waits;
        wait_idle();
        len = burst_len(bc);
        idx = int'(addr[AW+1:2]);
        avs_address    = addr;
        avs_burstcount = bc;
        avs_byteenable = 4'($urandom_range(0, 15));
        avs_read       = 1'b1;
        wait_accept(waits);
        avs_read = 1'b0;
        check("read_wait_states", 32'(waits), 32'(WS));
        if (bc > 3'd4) exp_err = 1'b1;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(model_mem[(idx + i) % DEPTH]);
            first_q.push_back(i == 0);
        end
        acc_q.push_back(cyc);
    endtask

    task automatic do_reset();
        avs_read  = 1'b0;
        avs_write = 1'b0;
        rst_n     = 1'b0;
        exp_q.delete();
        first_q.delete();
        acc_q.delete();
        exp_err = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0][31:0] d;
        logic [3:0][3:0]  be;
        logic [31:0]      a;
        logic [2:0]       bc;
        int               base;
        int               guard;

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_waitrequest",   32'(avs_waitrequest),   32'(WS != 0));
        check("reset_readdatavalid", 32'(avs_readdatavalid), 32'd0);
        check("reset_readdata",      avs_readdata,           32'd0);
        check("reset_protocol_err",  32'(protocol_error),    32'd0);
        check("reset_state_idle",    32'(dbg_state),         32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fill the whole RAM so every later read has a known value.
        for (int k = 0; k < DEPTH / 4; k++) begin
            for (int i = 0; i < 4; i++) d[i] = $urandom();
            do_write(32'(k * 16), 3'd4, d, '1, 1'b0, 1'b0);
        end

        // Back-to-back 4-beat write then read at 0x100.
        d = {32'h44, 32'h33, 32'h22, 32'h11};
        do_write(32'h0000_0100, 3'd4, d, '1, 1'b0, 1'b0);
        do_read(32'h0000_0100, 3'd4);

        // Byte lanes: only lanes 0 and 2 of AABBCCDD land on a zeroed dword.
        d = '0;
        do_write(32'h0000_0008, 3'd1, d, '1, 1'b0, 1'b0);
        d[0] = 32'hAABB_CCDD;
        be[0] = 4'b0101;
        do_write(32'h0000_0008, 3'd1, d, be, 1'b0, 1'b0);
        do_read(32'h0000_0008, 3'd1);

        // Two-beat read exercising the wait-state count.
        do_read(32'h0000_0020, 3'd2);

        // Burst crossing the top of the RAM wraps to dword 0.
        for (int i = 0; i < 4; i++) d[i] = $urandom();
        do_write(32'hF000_003C, 3'd3, d, '1, 1'b1, 1'b0);
        do_read(32'h0000_003C, 3'd3);
        do_read(32'h0000_0000, 3'd1);
        do_read(32'h0000_0004, 3'd1);

        // Randomized mix of legal reads and writes.
        for (int n = 0; n < 40; n++) begin
            a  = $urandom();
            bc = 3'($urandom_range(0, 4));
            for (int i = 0; i < 4; i++) begin
                d[i]  = $urandom();
                be[i] = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 1) == 0) do_write(a, bc, d, be, 1'b1, 1'b0);
            else                           do_read(a, bc);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();
        check("protocol_err_clean", 32'(protocol_error), 32'(exp_err));

        // Oversized burstcount clamps to 4 beats and flags an error.
        for (int i = 0; i < 4; i++) d[i] = $urandom();
        do_write(32'h0000_0010, 3'd6, d, '1, 1'b0, 1'b0);
        do_read(32'h0000_0010, 3'd7);
        wait_idle();
        check("protocol_err_burst", 32'(protocol_error), 32'(exp_err));

        do_reset();
        #1;
        check("protocol_err_cleared", 32'(protocol_error), 32'd0);

        // Simultaneous read and write: write lands, read is dropped.
        d[0] = 32'hCAFE_F00D;
        do_write(32'h0000_0014, 3'd1, d, '1, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        #1;
        check("protocol_err_rdwr", 32'(protocol_error), 32'(exp_err));
        do_read(32'h0000_0014, 3'd1);
        wait_idle();
        check("protocol_err_sticky", 32'(protocol_error), 32'(exp_err));

        // Reset after the second of four read beats.
        base = beats_seen;
        do_read(32'h0000_0010, 3'd4);
        guard = 0;
        while (beats_seen < base + 2 && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("reset_burst_beats_before", 32'(beats_seen - base), 32'd2);
        rst_n = 1'b0;
        #1;
        check("reset_burst_readdatavalid", 32'(avs_readdatavalid), 32'd0);
        check("reset_burst_state",         32'(dbg_state),         32'd0);
        exp_q.delete();
        first_q.delete();
        acc_q.delete();
        exp_err = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        check("reset_burst_state_after", 32'(dbg_state), 32'd0);

        // RAM survives reset.
        do_read(32'h0000_0010, 3'd4);
        do_read(32'h0000_003C, 3'd3);
        wait_idle();
        check("protocol_err_final", 32'(protocol_error), 32'(exp_err));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hang guard.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
